// File: rtl/pong_game_logic.sv
// Per-frame game-state engine for Pong: paddle, ball, walls, scoring and serve delay.
// Every state register changes only on a frame tick, except the miss pulse, which self-clears.
module pong_game_logic #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int X_POS_W      = 10,
  parameter int Y_POS_W      = 9,
  parameter int PADDLE_X     = 16,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               frame_tick_i,
  input  logic [1:0]         keys_i,
  output logic [Y_POS_W-1:0] paddle_y_o,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic               ball_visible_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               miss_o
);

  localparam int CNT_W = $clog2(SERVE_FRAMES);

  localparam logic [Y_POS_W-1:0] PADDLE_Y_RST = Y_POS_W'((V_RES - PADDLE_H) / 2);
  localparam logic [X_POS_W-1:0] BALL_X_RST   = X_POS_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [Y_POS_W-1:0] BALL_Y_RST   = Y_POS_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(SERVE_FRAMES - 1);

  localparam logic signed [Y_POS_W:0] Y_STEP  = (Y_POS_W+1)'(PADDLE_STEP);
  localparam logic signed [Y_POS_W:0] Y_SPD   = (Y_POS_W+1)'(BALL_SPEED);
  localparam logic signed [Y_POS_W:0] Y_BALL  = (Y_POS_W+1)'(BALL_SIZE);
  localparam logic signed [Y_POS_W:0] Y_PAD_H = (Y_POS_W+1)'(PADDLE_H);
  localparam logic signed [Y_POS_W:0] PY_MAX  = (Y_POS_W+1)'(V_RES - PADDLE_H);
  localparam logic signed [Y_POS_W:0] BY_MAX  = (Y_POS_W+1)'(V_RES - BALL_SIZE);
  localparam logic signed [X_POS_W:0] X_SPD   = (X_POS_W+1)'(BALL_SPEED);
  localparam logic signed [X_POS_W:0] BX_MAX  = (X_POS_W+1)'(H_RES - BALL_SIZE);
  localparam logic signed [X_POS_W:0] BX_PAD  = (X_POS_W+1)'(PADDLE_X + PADDLE_W);

  typedef enum logic {ST_SERVE, ST_PLAY} state_e;

  state_e               state_q, state_d;
  logic [Y_POS_W-1:0]   paddle_y_q, paddle_y_d;
  logic [X_POS_W-1:0]   ball_x_q, ball_x_d;
  logic [Y_POS_W-1:0]   ball_y_q, ball_y_d;
  logic                 visible_q, visible_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 miss_q, miss_d;
  logic                 dx_right_q, dx_right_d;
  logic                 dy_down_q, dy_down_d;
  logic                 dy_tog_q, dy_tog_d;
  logic [CNT_W-1:0]     serve_cnt_q, serve_cnt_d;

  // One extra signed bit so subtractions go negative instead of wrapping.
  logic signed [Y_POS_W:0] py_s, by_s, py_up, py_dn, by_up, by_dn;
  logic signed [X_POS_W:0] bx_s, bx_lf, bx_rt;
  logic                    overlap;

  assign py_s    = $signed({1'b0, paddle_y_q});
  assign by_s    = $signed({1'b0, ball_y_q});
  assign bx_s    = $signed({1'b0, ball_x_q});
  assign py_up   = py_s - Y_STEP;
  assign py_dn   = py_s + Y_STEP;
  assign by_up   = by_s - Y_SPD;
  assign by_dn   = by_s + Y_SPD;
  assign bx_lf   = bx_s - X_SPD;
  assign bx_rt   = bx_s + X_SPD;
  assign overlap = (by_s + Y_BALL > py_s) && (by_s < py_s + Y_PAD_H);

  always_comb begin
    state_d     = state_q;
    paddle_y_d  = paddle_y_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    visible_d   = visible_q;
    score_d     = score_q;
    miss_d      = 1'b0;
    dx_right_d  = dx_right_q;
    dy_down_d   = dy_down_q;
    dy_tog_d    = dy_tog_q;
    serve_cnt_d = serve_cnt_q;

    if (frame_tick_i) begin
      if (keys_i == 2'b01) begin
        paddle_y_d = py_up[Y_POS_W] ? '0 : py_up[Y_POS_W-1:0];
      end else if (keys_i == 2'b10) begin
        paddle_y_d = (py_dn > PY_MAX) ? PY_MAX[Y_POS_W-1:0] : py_dn[Y_POS_W-1:0];
      end

      if (state_q == ST_SERVE) begin
        if (serve_cnt_q == CNT_LAST) begin
          serve_cnt_d = '0;
          state_d     = ST_PLAY;
          visible_d   = 1'b1;
          dx_right_d  = 1'b1;
          dy_down_d   = ~dy_tog_q;
          dy_tog_d    = ~dy_tog_q;
        end else begin
          serve_cnt_d = serve_cnt_q + 1'b1;
        end
      end else begin
        if (!dy_down_q) begin
          if (by_s <= Y_SPD) begin
            ball_y_d  = '0;
            dy_down_d = 1'b1;
          end else begin
            ball_y_d = by_up[Y_POS_W-1:0];
          end
        end else if (by_dn >= BY_MAX) begin
          ball_y_d  = BY_MAX[Y_POS_W-1:0];
          dy_down_d = 1'b0;
        end else begin
          ball_y_d = by_dn[Y_POS_W-1:0];
        end

        if (dx_right_q) begin
          if (bx_rt >= BX_MAX) begin
            ball_x_d   = BX_MAX[X_POS_W-1:0];
            dx_right_d = 1'b0;
          end else begin
            ball_x_d = bx_rt[X_POS_W-1:0];
          end
        end else if (bx_lf <= BX_PAD) begin
          if (overlap) begin
            ball_x_d   = BX_PAD[X_POS_W-1:0];
            dx_right_d = 1'b1;
            score_d    = (score_q == '1) ? score_q : score_q + 1'b1;
          end else begin
            // A miss overrides the vertical update computed above.
            miss_d      = 1'b1;
            score_d     = '0;
            visible_d   = 1'b0;
            ball_x_d    = BALL_X_RST;
            ball_y_d    = BALL_Y_RST;
            dy_down_d   = dy_down_q;
            state_d     = ST_SERVE;
            serve_cnt_d = '0;
          end
        end else begin
          ball_x_d = bx_lf[X_POS_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_SERVE;
      paddle_y_q  <= PADDLE_Y_RST;
      ball_x_q    <= BALL_X_RST;
      ball_y_q    <= BALL_Y_RST;
      visible_q   <= 1'b0;
      score_q     <= '0;
      miss_q      <= 1'b0;
      dx_right_q  <= 1'b1;
      dy_down_q   <= 1'b1;
      dy_tog_q    <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      paddle_y_q  <= paddle_y_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      visible_q   <= visible_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      dx_right_q  <= dx_right_d;
      dy_down_q   <= dy_down_d;
      dy_tog_q    <= dy_tog_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign paddle_y_o     = paddle_y_q;
  assign ball_x_o       = ball_x_q;
  assign ball_y_o       = ball_y_q;
  assign ball_visible_o = visible_q;
  assign score_o        = score_q;
  assign miss_o         = miss_q;

endmodule

// File: tb/tb_pong_game_logic.sv
// Bench for pong_game_logic: directed serve/clamp sequence, random play and a paddle that
// tracks the ball, all compared every cycle against a plain-arithmetic game model.
module tb_pong_game_logic;

  localparam int H_RES = 640, V_RES = 480, PADDLE_X = 16, PADDLE_W = 8, PADDLE_H = 64;
  localparam int BALL = 8, STEP = 4, SPEED = 2, SERVE_FRAMES = 60, SCORE_MAX = 15;

  logic       clk, rst_n, frame_tick;
  logic [1:0] keys;
  logic [8:0] paddle_y_o, ball_y_o;
  logic [9:0] ball_x_o;
  logic       ball_visible_o, miss_o;
  logic [3:0] score_o;

  pong_game_logic dut (
    .clk_i(clk), .rst_n_i(rst_n), .frame_tick_i(frame_tick), .keys_i(keys),
    .paddle_y_o(paddle_y_o), .ball_x_o(ball_x_o), .ball_y_o(ball_y_o),
    .ball_visible_o(ball_visible_o), .score_o(score_o), .miss_o(miss_o)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0, n_pass = 0;
  int dut_misses = 0, max_score = 0, ticks = 0;

  // reference model state
  int m_py, m_bx, m_by, m_vis, m_score, m_miss, m_cnt, m_misses = 0;
  bit m_serve, m_dxr, m_dyd, m_tog;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_py = (V_RES - PADDLE_H) / 2; m_bx = (H_RES - BALL) / 2; m_by = (V_RES - BALL) / 2;
    m_vis = 0; m_score = 0; m_miss = 0; m_cnt = 0;
    m_serve = 1; m_dxr = 1; m_dyd = 1; m_tog = 0;
  endtask

  task automatic model_step(input bit tick, input logic [1:0] k);
    int p0, ny;
    bit ndy;
    m_miss = 0;
    if (!tick) return;
    p0 = m_py;
    if (k == 2'b01) m_py = (m_py - STEP < 0) ? 0 : m_py - STEP;
    else if (k == 2'b10) m_py = (m_py + STEP > V_RES - PADDLE_H) ? V_RES - PADDLE_H : m_py + STEP;
    if (m_serve) begin
      if (m_cnt == SERVE_FRAMES - 1) begin
        m_cnt = 0; m_serve = 0; m_vis = 1; m_dxr = 1; m_dyd = !m_tog; m_tog = !m_tog;
      end else m_cnt++;
      return;
    end
    ndy = m_dyd;
    if (!m_dyd) begin
      if (m_by <= SPEED) begin ny = 0; ndy = 1; end else ny = m_by - SPEED;
    end else begin
      if (m_by + SPEED >= V_RES - BALL) begin ny = V_RES - BALL; ndy = 0; end else ny = m_by + SPEED;
    end
    if (m_dxr) begin
      if (m_bx + SPEED >= H_RES - BALL) begin m_bx = H_RES - BALL; m_dxr = 0; end
      else m_bx = m_bx + SPEED;
    end else if (m_bx - SPEED <= PADDLE_X + PADDLE_W) begin
      if (m_by + BALL > p0 && m_by < p0 + PADDLE_H) begin
        m_bx = PADDLE_X + PADDLE_W; m_dxr = 1;
        if (m_score < SCORE_MAX) m_score++;
      end else begin
        m_miss = 1; m_misses++; m_score = 0; m_vis = 0;
        m_bx = (H_RES - BALL) / 2; m_by = (V_RES - BALL) / 2;
        m_serve = 1; m_cnt = 0;
        return;
      end
    end else m_bx = m_bx - SPEED;
    m_by = ny; m_dyd = ndy;
  endtask

  // scoreboard: all outputs against the model, every cycle
  task automatic compare_all();
    check_eq("paddle_y", paddle_y_o, m_py);
    check_eq("ball_x", ball_x_o, m_bx);
    check_eq("ball_y", ball_y_o, m_by);
    check_eq("visible", ball_visible_o, m_vis);
    check_eq("score", score_o, m_score);
    check_eq("miss", miss_o, m_miss);
    if (miss_o) dut_misses++;
    if (score_o > max_score) max_score = score_o;
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic do_cycle(input bit tick, input logic [1:0] k);
    frame_tick = tick;
    keys = k;
    model_step(tick, k);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_tick(input logic [1:0] k, input int max_gap);
    int gap;
    gap = $urandom_range(0, max_gap);
    for (int i = 0; i < gap; i++) do_cycle(1'b0, 2'($urandom_range(0, 3)));
    do_cycle(1'b1, k);
    ticks++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_paddle_y"}, paddle_y_o, 208);
    check_eq({tag, "_ball_x"}, ball_x_o, 316);
    check_eq({tag, "_ball_y"}, ball_y_o, 236);
    check_eq({tag, "_visible"}, ball_visible_o, 0);
    check_eq({tag, "_score"}, score_o, 0);
    check_eq({tag, "_miss"}, miss_o, 0);
  endtask

  task automatic apply_reset_midcycle(input string tag);
    #2 rst_n = 1'b0;
    frame_tick = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] track_keys();
    int pc, bc;
    pc = m_py + PADDLE_H / 2;
    bc = m_by + BALL / 2;
    if (bc < pc - 2) return 2'b01;
    if (bc > pc + 2) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    rst_n = 1'b1; frame_tick = 1'b0; keys = 2'b00;
    @(negedge clk);
    apply_reset_midcycle("rst");

    // paddle clamp at the top while the ball waits for its first serve
    for (int i = 1; i <= 55; i++) begin
      do_tick(2'b01, 2);
      if (i == 51) check_eq("clamp_51", paddle_y_o, 4);
      if (i == 52) check_eq("clamp_52", paddle_y_o, 0);
    end
    check_eq("clamp_55", paddle_y_o, 0);
    for (int i = 0; i < 4; i++) do_tick(2'b11, 2);
    check_eq("keys11_hold", paddle_y_o, 0);
    check_eq("serve59_hidden", ball_visible_o, 0);
    do_tick(2'b00, 2);
    check_eq("serve60_visible", ball_visible_o, 1);
    check_eq("serve60_x", ball_x_o, 316);
    check_eq("serve60_y", ball_y_o, 236);
    do_tick(2'b00, 2);
    check_eq("serve61_x", ball_x_o, 318);
    check_eq("serve61_y", ball_y_o, 238);

    // random play, including back-to-back tick cycles
    for (int i = 0; i < 2500; i++) do_tick(2'($urandom_range(0, 3)), 3);

    apply_reset_midcycle("midrst");

    // paddle follows the ball long enough to saturate the score
    for (int i = 0; i < 10000; i++) do_tick(track_keys(), 1);

    check_eq("miss_count", dut_misses, m_misses);
    check_eq("score_saturated", max_score, SCORE_MAX);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
